// File: rtl/eeg_pea_pkg.sv
// Shared types and constants for the PE-array output collector.
// Holds the collector FSM encoding, lane-count constants and the ORAM address helper.
package eeg_pea_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int PE_COL      = 4;
  localparam int PE_ROW      = 4;
  localparam int PE_NUM      = PE_COL * PE_ROW;
  localparam int LANE_W      = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam int DATA_OUT_DW = 8;
  localparam int OMUX_ADD_AW = 8;
  localparam int ORAM_ADD_AW = 12;
  localparam int SUM_W       = 32;

  // Untruncated linear address; callers keep the low ORAM_ADD_AW bits.
  function automatic logic [SUM_W-1:0] oram_addr_sum(input logic [SUM_W-1:0] base,
                                                     input logic [SUM_W-1:0] add,
                                                     input logic [SUM_W-1:0] lane,
                                                     input logic [SUM_W-1:0] pe_num);
    return base + add * pe_num + lane;
  endfunction

endpackage

// File: rtl/eeg_pea_out_col_if.sv
// Lane output stream plus ORAM write port of the collector.
// master = PE array / ORAM side, slave = collector.
interface eeg_pea_out_col_if #(
  parameter int PE_COL      = 4,
  parameter int PE_ROW      = 4,
  parameter int DATA_OUT_DW = 8,
  parameter int OMUX_ADD_AW = 8,
  parameter int ORAM_ADD_AW = 12
);
  logic [PE_COL-1:0][PE_ROW-1:0]                  OUT_VLD;
  logic [PE_COL-1:0][PE_ROW-1:0]                  OUT_LST;
  logic [PE_COL-1:0][PE_ROW-1:0]                  OUT_RDY;
  logic [PE_COL-1:0][PE_ROW-1:0][DATA_OUT_DW-1:0] OUT_DAT;
  logic [PE_COL-1:0][PE_ROW-1:0][OMUX_ADD_AW-1:0] OUT_ADD;
  logic                                           ORAM_VLD;
  logic                                           ORAM_RDY;
  logic [ORAM_ADD_AW-1:0]                         ORAM_ADD;
  logic [DATA_OUT_DW-1:0]                         ORAM_DAT;

  modport master (
    output OUT_VLD, OUT_LST, OUT_DAT, OUT_ADD, ORAM_RDY,
    input  OUT_RDY, ORAM_VLD, ORAM_ADD, ORAM_DAT
  );

  modport slave (
    input  OUT_VLD, OUT_LST, OUT_DAT, OUT_ADD, ORAM_RDY,
    output OUT_RDY, ORAM_VLD, ORAM_ADD, ORAM_DAT
  );
endinterface

// File: rtl/eeg_pea_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr_i wins, wrapping at N.
// Purely combinational; the caller owns the pointer register.
module eeg_pea_rr_arb
  import eeg_pea_pkg::*;
#(
  parameter int N  = PE_NUM,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW:0]   cand_sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    vld_o    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < N; i++) begin
      cand_sum = {1'b0, ptr_i} + (IW+1)'(i);
      if (cand_sum >= (IW+1)'(N)) cand_sum = cand_sum - (IW+1)'(N);
      cand = cand_sum[IW-1:0];
      if (en_i && !vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/eeg_pea_out_col.sv
// PE-array output collector: round-robin lane arbitration into one registered ORAM write port.
// Optional address-overflow flag ERR_FLG is built when EEG_PEA_OUT_CHK_EN is defined.
//
//  state    | meaning
//  ST_IDLE  | waiting for CFG_START
//  ST_RUN   | granting lanes until every lane has delivered its LST word
//  ST_FLUSH | waiting for the last slot word to drain into ORAM
//  ST_DONE  | one-cycle completion pulse
module eeg_pea_out_col
  import eeg_pea_pkg::*;
#(
  parameter int PE_COL      = eeg_pea_pkg::PE_COL,
  parameter int PE_ROW      = eeg_pea_pkg::PE_ROW,
  parameter int DATA_OUT_DW = eeg_pea_pkg::DATA_OUT_DW,
  parameter int OMUX_ADD_AW = eeg_pea_pkg::OMUX_ADD_AW,
  parameter int ORAM_ADD_AW = eeg_pea_pkg::ORAM_ADD_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   IS_IDLE,
  input  logic                   CFG_START,
  input  logic [ORAM_ADD_AW-1:0] CFG_ORAM_BASE,
  output logic                   DONE,
`ifdef EEG_PEA_OUT_CHK_EN
  output logic                   ERR_FLG,
`endif
  eeg_pea_out_col_if.slave       bus
);

  localparam int PN = PE_COL * PE_ROW;
  localparam int LW = (PN > 1) ? $clog2(PN) : 1;

  state_e                 state_q, state_d;
  logic [ORAM_ADD_AW-1:0] base_q, base_d;
  logic [PN-1:0]          lst_seen_q, lst_seen_d;
  logic [LW-1:0]          ptr_q, ptr_d;
  logic                   slot_vld_q, slot_vld_d;
  logic [ORAM_ADD_AW-1:0] slot_add_q, slot_add_d;
  logic [DATA_OUT_DW-1:0] slot_dat_q, slot_dat_d;

  logic [PN-1:0]             vld_flat, lst_flat, gnt_oh;
  logic [PN*DATA_OUT_DW-1:0] dat_flat;
  logic [PN*OMUX_ADD_AW-1:0] add_flat;
  logic [DATA_OUT_DW-1:0]    dat_sel;
  logic [OMUX_ADD_AW-1:0]    add_sel;
  logic [LW-1:0]             gnt_idx;
  logic                      gnt_vld, slot_free, arb_en;
  logic [ORAM_ADD_AW-1:0]    addr_new;

  // Packed [col][row] flattens so that bit L is lane col*PE_ROW+row.
  assign vld_flat = bus.OUT_VLD;
  assign lst_flat = bus.OUT_LST;
  assign dat_flat = bus.OUT_DAT;
  assign add_flat = bus.OUT_ADD;

  assign slot_free = !slot_vld_q || bus.ORAM_RDY;
  assign arb_en    = (state_q == ST_RUN) && slot_free;

  eeg_pea_rr_arb #(.N(PN), .IW(LW)) u_arb (
    .req_i (vld_flat & ~lst_seen_q),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  always_comb begin
    dat_sel = '0;
    add_sel = '0;
    for (int l = 0; l < PN; l++) begin
      if (gnt_oh[l]) begin
        dat_sel = dat_flat[l*DATA_OUT_DW +: DATA_OUT_DW];
        add_sel = add_flat[l*OMUX_ADD_AW +: OMUX_ADD_AW];
      end
    end
  end

`ifdef EEG_PEA_OUT_CHK_EN
  logic [SUM_W-1:0] sum_full;
  logic             err_q, err_d;

  assign sum_full = oram_addr_sum(SUM_W'(base_q), SUM_W'(add_sel), SUM_W'(gnt_idx), SUM_W'(PN));
  assign addr_new = sum_full[ORAM_ADD_AW-1:0];

  always_comb begin
    err_d = err_q;
    if (gnt_vld && (sum_full[SUM_W-1:ORAM_ADD_AW] != '0)) err_d = 1'b1;
    if ((state_q == ST_IDLE) && CFG_START) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign ERR_FLG = err_q;
`else
  assign addr_new = ORAM_ADD_AW'(oram_addr_sum(SUM_W'(base_q), SUM_W'(add_sel),
                                               SUM_W'(gnt_idx), SUM_W'(PN)));
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    lst_seen_d = lst_seen_q;
    ptr_d      = ptr_q;
    slot_vld_d = slot_vld_q;
    slot_add_d = slot_add_q;
    slot_dat_d = slot_dat_q;

    // A grant only happens when the slot is free, so load wins over drain.
    if (gnt_vld) begin
      slot_vld_d = 1'b1;
      slot_add_d = addr_new;
      slot_dat_d = dat_sel;
      ptr_d      = (gnt_idx == LW'(PN-1)) ? '0 : gnt_idx + 1'b1;
      if (|(lst_flat & gnt_oh)) lst_seen_d = lst_seen_q | gnt_oh;
    end else if (bus.ORAM_RDY) begin
      slot_vld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (CFG_START) begin
          state_d    = ST_RUN;
          base_d     = CFG_ORAM_BASE;
          lst_seen_d = '0;
        end
      end
      ST_RUN:   if (&lst_seen_d) state_d = ST_FLUSH;
      ST_FLUSH: if (slot_free)   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      lst_seen_q <= '0;
      ptr_q      <= '0;
      slot_vld_q <= 1'b0;
      slot_add_q <= '0;
      slot_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      lst_seen_q <= lst_seen_d;
      ptr_q      <= ptr_d;
      slot_vld_q <= slot_vld_d;
      slot_add_q <= slot_add_d;
      slot_dat_q <= slot_dat_d;
    end
  end

  assign bus.OUT_RDY  = gnt_oh;
  assign bus.ORAM_VLD = slot_vld_q;
  assign bus.ORAM_ADD = slot_add_q;
  assign bus.ORAM_DAT = slot_dat_q;
  assign IS_IDLE      = (state_q == ST_IDLE);
  assign DONE         = (state_q == ST_DONE);

endmodule

// File: tb/tb_eeg_pea_out_col.sv
// Bench for eeg_pea_out_col: directed scenarios plus random traffic against a lane-level model.
// ERR_FLG is checked only when EEG_PEA_OUT_CHK_EN is defined.
module tb_eeg_pea_out_col;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CFG_START;
  logic [11:0] CFG_ORAM_BASE;
  logic        IS_IDLE;
  logic        DONE;
`ifdef EEG_PEA_OUT_CHK_EN
  logic        ERR_FLG;
`endif

  always #5 clk = ~clk;

  eeg_pea_out_col_if #(.PE_COL(4), .PE_ROW(4), .DATA_OUT_DW(8), .OMUX_ADD_AW(8),
                       .ORAM_ADD_AW(12)) bus ();

  eeg_pea_out_col dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IS_IDLE       (IS_IDLE),
    .CFG_START     (CFG_START),
    .CFG_ORAM_BASE (CFG_ORAM_BASE),
    .DONE          (DONE),
`ifdef EEG_PEA_OUT_CHK_EN
    .ERR_FLG       (ERR_FLG),
`endif
    .bus           (bus)
  );

  // lane stimulus
  logic [15:0] s_vld, s_lst;
  logic [7:0]  s_dat [16];
  logic [7:0]  s_add [16];
  logic        s_rdy;

  // reference model: 0 idle, 1 run, 2 flush, 3 done
  int          m_state, m_ptr, m_g;
  logic [15:0] m_lst;
  logic [11:0] m_base, m_sa;
  logic [7:0]  m_sd;
  logic        m_sv, m_err;
  int          m_wr, d_wr, done_cnt;
  logic [15:0] last_rdy;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_lst = '0; m_base = '0;
    m_sv = 1'b0; m_sa = '0; m_sd = '0; m_err = 1'b0; m_g = -1;
  endtask

  task automatic drive();
    logic [127:0] fd;
    logic [127:0] fa;
    for (int l = 0; l < 16; l++) begin
      fd[l*8 +: 8] = s_dat[l];
      fa[l*8 +: 8] = s_add[l];
    end
    bus.OUT_VLD  = s_vld;
    bus.OUT_LST  = s_lst;
    bus.OUT_DAT  = fd;
    bus.OUT_ADD  = fa;
    bus.ORAM_RDY = s_rdy;
  endtask

  // One clock: check grant before the edge, advance the model, check registered outputs after.
  task automatic cyc();
    int   g, ln, nst, sum;
    logic free;
    drive();
    #1;
    free = !m_sv || s_rdy;
    g = -1;
    if (m_state == 1 && free) begin
      for (int i = 0; i < 16; i++) begin
        ln = (m_ptr + i) % 16;
        if (g < 0 && s_vld[ln] && !m_lst[ln]) g = ln;
      end
    end
    last_rdy = bus.OUT_RDY;
    chk("out_rdy", 32'(bus.OUT_RDY), (g >= 0) ? (32'd1 << g) : 32'd0);
    if (bus.ORAM_VLD && bus.ORAM_RDY) d_wr++;
    if (m_sv && s_rdy) m_wr++;
    m_g = g;
    nst = m_state;
    case (m_state)
      0: if (CFG_START) begin
           nst = 1; m_base = CFG_ORAM_BASE; m_lst = '0; m_err = 1'b0;
         end
      2: if (free) nst = 3;
      3: nst = 0;
      default: ;
    endcase
    if (g >= 0) begin
      sum  = int'(m_base) + int'(s_add[g]) * 16 + g;
      m_sa = sum[11:0];
      m_sd = s_dat[g];
      m_sv = 1'b1;
      m_ptr = (g + 1) % 16;
      if (s_lst[g]) m_lst[g] = 1'b1;
      if (sum > 4095) m_err = 1'b1;
    end else if (s_rdy) begin
      m_sv = 1'b0;
    end
    if (m_state == 1 && m_lst == 16'hFFFF) nst = 2;
    m_state = nst;
    @(posedge clk);
    #1;
    chk("oram_vld", 32'(bus.ORAM_VLD), 32'(m_sv));
    chk("oram_add", 32'(bus.ORAM_ADD), 32'(m_sa));
    chk("oram_dat", 32'(bus.ORAM_DAT), 32'(m_sd));
    chk("done", 32'(DONE), 32'(m_state == 3));
    chk("is_idle", 32'(IS_IDLE), 32'(m_state == 0));
`ifdef EEG_PEA_OUT_CHK_EN
    chk("err_flg", 32'(ERR_FLG), 32'(m_err));
`endif
    if (DONE) done_cnt++;
  endtask

  task automatic start(input logic [11:0] base);
    CFG_START = 1'b1;
    CFG_ORAM_BASE = base;
    cyc();
    CFG_START = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_vld", 32'(bus.ORAM_VLD), 32'd0);
    chk("rst_idle", 32'(IS_IDLE), 32'd1);
    chk("rst_rdy", 32'(bus.OUT_RDY), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_lanes();
    for (int l = 0; l < 16; l++) begin
      s_dat[l] = 8'($urandom);
      s_add[l] = 8'($urandom);
    end
  endtask

  int          cnt [16];
  int          w0, d0;
  logic [19:0] hold;

  initial begin
    rst_n = 1'b0; CFG_START = 1'b0; CFG_ORAM_BASE = '0;
    s_vld = '0; s_lst = '0; s_rdy = 1'b1;
    for (int l = 0; l < 16; l++) begin s_dat[l] = '0; s_add[l] = '0; end
    m_wr = 0; d_wr = 0; done_cnt = 0; last_rdy = '0;
    model_reset();
    drive();
    #12;
    chk("reset_idle", 32'(IS_IDLE), 32'd1);
    chk("reset_rdy", 32'(bus.OUT_RDY), 32'd0);
    chk("reset_vld", 32'(bus.ORAM_VLD), 32'd0);
    chk("reset_add", 32'(bus.ORAM_ADD), 32'd0);
    chk("reset_dat", 32'(bus.ORAM_DAT), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // all lanes valid: strict 0..15 order then wrap, one write per cycle
    start(12'h000);
    s_vld = 16'hFFFF;
    w0 = d_wr;
    for (int i = 0; i < 20; i++) begin
      rand_lanes();
      cyc();
      chk("rr_order", 32'(last_rdy), 32'd1 << (i % 16));
    end
    chk("wr_rate", 32'(d_wr - w0), 32'd19);

    // backpressure: slot frozen, no grants
    s_rdy = 1'b0;
    hold = {bus.ORAM_ADD, bus.ORAM_DAT};
    for (int i = 0; i < 5; i++) begin
      rand_lanes();
      cyc();
      chk("bp_rdy", 32'(last_rdy), 32'd0);
      chk("bp_hold", 32'({bus.ORAM_ADD, bus.ORAM_DAT}), 32'(hold));
    end
    s_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin rand_lanes(); cyc(); end
    chk("bp_wr_count", 32'(d_wr), 32'(m_wr));

    // reset while the slot holds a word
    chk("slot_full", 32'(bus.ORAM_VLD), 32'd1);
    do_reset();

    // single lane after restart
    s_vld = 16'h0020; s_add[5] = 8'd3; s_dat[5] = 8'hA5;
    start(12'h100);
    s_vld = 16'h0020;
    cyc();
    chk("single_add", 32'(bus.ORAM_ADD), 32'h135);
    chk("single_dat", 32'(bus.ORAM_DAT), 32'hA5);
    s_vld = '0;
    cyc(); cyc();
    do_reset();

    // completion: two words per lane, second carries LST
    for (int l = 0; l < 16; l++) cnt[l] = 0;
    d0 = done_cnt;
    w0 = d_wr;
    start(12'($urandom_range(0, 255)));
    for (int c = 0; c < 600 && (done_cnt - d0) == 0; c++) begin
      rand_lanes();
      for (int l = 0; l < 16; l++) begin
        s_vld[l] = (cnt[l] < 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        s_lst[l] = (cnt[l] >= 1);
      end
      s_rdy = ($urandom_range(0, 3) != 0);
      cyc();
      if (m_g >= 0) cnt[m_g]++;
    end
    s_rdy = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("cmp_writes", 32'(d_wr - w0), 32'd32);
    chk("cmp_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("cmp_idle", 32'(IS_IDLE), 32'd1);
    s_vld = '0; s_lst = '0;

    // address wrap at the top of ORAM
    start(12'hFF0);
    s_vld = 16'h8000; s_add[15] = 8'd0; s_dat[15] = 8'h3C;
    cyc();
    chk("wrap_top", 32'(bus.ORAM_ADD), 32'hFFF);
    s_add[15] = 8'd1;
    cyc();
    chk("wrap_low", 32'(bus.ORAM_ADD), 32'h00F);
`ifdef EEG_PEA_OUT_CHK_EN
    chk("wrap_err", 32'(ERR_FLG), 32'd1);
`endif
    s_vld = '0;
    cyc();
    do_reset();

    // random traffic, random starts (ignored outside idle)
    for (int c = 0; c < 500; c++) begin
      rand_lanes();
      s_vld = 16'($urandom);
      for (int l = 0; l < 16; l++) s_lst[l] = ($urandom_range(0, 5) == 0);
      s_rdy = ($urandom_range(0, 3) != 0);
      CFG_START = ($urandom_range(0, 15) == 0);
      CFG_ORAM_BASE = 12'($urandom);
      cyc();
    end
    CFG_START = 1'b0;
    chk("wr_total", 32'(d_wr), 32'(m_wr));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
